// File: rtl/ac97_sample_arbiter.sv
// ac97_sample_arbiter: round-robin arbiter with a burst quantum.
// It shares the sys-clock write port of the AC97 sample FIFO between the CPU
// sample register (A) and the tone/DMA source (B). A one-entry output register
// holds the chosen sample and stalls on fifo_full, so samples are never lost or
// duplicated.
module ac97_sample_arbiter #(
    parameter int DATA_WIDTH  = 20,
    parameter int BURST       = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   a_valid,
    input  logic [DATA_WIDTH-1:0]  a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [DATA_WIDTH-1:0]  b_data,
    output logic                   b_ready,
    input  logic                   fifo_full,
    output logic                   fifo_wr_en,
    output logic [DATA_WIDTH-1:0]  fifo_din,
    output logic [1:0]             owner,
    output logic [COUNT_WIDTH-1:0] sample_count
);

    localparam int            BW         = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST - 1);

    // The encoding doubles as the owner output: 00 idle, 01 A, 10 B.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_owner_q, last_owner_d;  // 0 = A, 1 = B
    logic [BW-1:0]          burst_cnt_q, burst_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic [COUNT_WIDTH-1:0] sample_count_q, sample_count_d;

    logic can_load;
    logic accept_a;
    logic accept_b;
    logic accept;
    logic own_is_b;
    logic own_valid;
    logic oth_valid;

    // The output register can take a new sample when it is empty or emptying this cycle.
    assign fifo_wr_en   = out_valid_q & ~fifo_full;
    assign can_load     = ~out_valid_q | fifo_wr_en;
    assign a_ready      = (state_q == GRANT_A) & can_load;
    assign b_ready      = (state_q == GRANT_B) & can_load;
    assign accept_a     = a_valid & a_ready;
    assign accept_b     = b_valid & b_ready;
    assign accept       = accept_a | accept_b;
    assign fifo_din     = out_data_q;
    assign owner        = state_q;
    assign sample_count = sample_count_q;

    // Next ownership: grant from IDLE, then hand over on burst end, owner drop or disable.
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        own_is_b     = (state_q == GRANT_B);
        own_valid    = own_is_b ? b_valid : a_valid;
        oth_valid    = own_is_b ? a_valid : b_valid;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (a_valid && b_valid) begin
                        state_d = last_owner_q ? GRANT_A : GRANT_B;
                    end else if (a_valid) begin
                        state_d = GRANT_A;
                    end else if (b_valid) begin
                        state_d = GRANT_B;
                    end
                end
            end
            GRANT_A, GRANT_B: begin
                // A stalled owner (valid but FIFO full) keeps the grant indefinitely.
                if ((accept && (burst_cnt_q == BURST_LAST)) || !own_valid || !enable) begin
                    last_owner_d = own_is_b;
                    burst_cnt_d  = '0;
                    if (enable && oth_valid) begin
                        state_d = own_is_b ? GRANT_A : GRANT_B;
                    end else if (enable && own_valid) begin
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register load/drain and the written-sample counter.
    always_comb begin
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        sample_count_d = sample_count_q + COUNT_WIDTH'(fifo_wr_en);
        if (accept_a) begin
            out_valid_d = 1'b1;
            out_data_d  = a_data;
        end else if (accept_b) begin
            out_valid_d = 1'b1;
            out_data_d  = b_data;
        end else if (fifo_wr_en) begin
            out_valid_d = 1'b0;
        end
    end

    // State and datapath registers; reset discards any held sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_owner_q   <= 1'b1;
            burst_cnt_q    <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            sample_count_q <= '0;
        end else begin
            state_q        <= state_d;
            last_owner_q   <= last_owner_d;
            burst_cnt_q    <= burst_cnt_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            sample_count_q <= sample_count_d;
        end
    end

endmodule

// File: tb/tb_ac97_sample_arbiter.sv
// Directed bench for ac97_sample_arbiter with a write-order scoreboard.
module tb_ac97_sample_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        a_valid;
    logic [19:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [19:0] b_data;
    logic        b_ready;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [19:0] fifo_din;
    logic [1:0]  owner;
    logic [31:0] sample_count;

    ac97_sample_arbiter #(
        .DATA_WIDTH (20),
        .BURST      (4),
        .COUNT_WIDTH(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .a_valid     (a_valid),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .b_valid     (b_valid),
        .b_data      (b_data),
        .b_ready     (b_ready),
        .fifo_full   (fifo_full),
        .fifo_wr_en  (fifo_wr_en),
        .fifo_din    (fifo_din),
        .owner       (owner),
        .sample_count(sample_count)
    );

    always #5 clk = ~clk;

    logic [19:0] aq[$];
    logic [19:0] bq[$];
    logic [19:0] exp_q[$];
    logic [19:0] exp_v;
    logic        a_gate, b_gate, a_fire, b_fire, no_b_owner, sb_ok;
    int          passed, total, cyc, first_wr, last_wr, guard;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // One clock: drive requesters at negedge, sample just after, commit handshakes after posedge.
    task automatic step();
        @(negedge clk);
        a_valid = a_gate && (aq.size() != 0);
        a_data  = (aq.size() != 0) ? aq[0] : 20'h0;
        b_valid = b_gate && (bq.size() != 0);
        b_data  = (bq.size() != 0) ? bq[0] : 20'h0;
        #1;
        a_fire = a_valid & a_ready;
        b_fire = b_valid & b_ready;
        if (no_b_owner) chk("t1_owner_not_b", {31'h0, owner == 2'b10}, 32'h0);
        if (fifo_wr_en) begin
            chk("wr_while_full", {31'h0, fifo_full}, 32'h0);
            sb_ok = (exp_q.size() != 0);
            chk("sb_nonempty", {31'h0, sb_ok}, 32'h1);
            if (sb_ok) begin
                exp_v = exp_q.pop_front();
                chk("sb_data", {12'h0, fifo_din}, {12'h0, exp_v});
            end
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (a_fire) void'(aq.pop_front());
        if (b_fire) void'(bq.pop_front());
    endtask

    task automatic drain(input string tag);
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            step();
            guard++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        passed = 0; total = 0; cyc = 0; first_wr = -1; last_wr = -1;
        rst = 1'b1; enable = 1'b0; fifo_full = 1'b0;
        a_gate = 1'b0; b_gate = 1'b0; a_fire = 1'b0; b_fire = 1'b0; no_b_owner = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;

        // Reset state
        step(); step();
        chk("rst_owner", {30'h0, owner}, 32'h0);
        chk("rst_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        chk("rst_a_ready", {31'h0, a_ready}, 32'h0);
        chk("rst_b_ready", {31'h0, b_ready}, 32'h0);
        chk("rst_count", sample_count, 32'h0);
        chk("rst_din", {12'h0, fifo_din}, 32'h0);
        rst = 1'b0;

        // 1: A streams -5..4 alone
        for (int i = -5; i <= 4; i++) begin
            aq.push_back(20'(i));
            exp_q.push_back(20'(i));
        end
        enable = 1'b1; a_gate = 1'b1; no_b_owner = 1'b1;
        first_wr = -1; last_wr = -1;
        drain("t1_drain");
        no_b_owner = 1'b0;
        chk("t1_contiguous", last_wr - first_wr, 9);
        chk("t1_count", sample_count, 10);

        // 2/4: both valid from reset exit, A wins first tie, bursts of 4
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            aq.push_back(20'(100 + i));
            bq.push_back(20'(200 + i));
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(20'(100 + 4 * k + i));
            for (int i = 0; i < 4; i++) exp_q.push_back(20'(200 + 4 * k + i));
        end
        a_gate = 1'b1; b_gate = 1'b1;
        step();
        chk("t2_first_owner_a", {30'h0, owner}, 32'h1);
        drain("t2_drain");
        chk("t2_count", sample_count, 24);

        // 3: FIFO full for 20 cycles while A streams
        for (int i = 0; i < 10; i++) begin
            aq.push_back(20'(300 + i));
            exp_q.push_back(20'(300 + i));
        end
        b_gate = 1'b0;
        step(); step(); step(); step();
        fifo_full = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t3_full_wr_en", {31'h0, fifo_wr_en}, 32'h0);
            chk("t3_full_a_ready", {31'h0, a_ready}, 32'h0);
            chk("t3_full_owner", {30'h0, owner}, 32'h1);
        end
        chk("t3_count_frozen", sample_count, 26);
        chk("t3_one_held", exp_q.size() - aq.size(), 1);
        fifo_full = 1'b0;
        drain("t3_drain");
        chk("t3_count", sample_count, 34);

        // 5: disable mid-burst with a sample held, then re-enable
        for (int i = 0; i < 8; i++) begin
            aq.push_back(20'(400 + i));
            bq.push_back(20'(500 + i));
        end
        for (int i = 0; i < 3; i++) exp_q.push_back(20'(400 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(20'(500 + i));
        for (int i = 3; i < 7; i++) exp_q.push_back(20'(400 + i));
        for (int i = 4; i < 8; i++) exp_q.push_back(20'(500 + i));
        exp_q.push_back(20'(407));
        a_gate = 1'b1; b_gate = 1'b0;
        step(); step(); step();
        enable = 1'b0; b_gate = 1'b1;
        step();
        chk("t5_accept_completes", aq.size(), 5);
        for (int i = 0; i < 3; i++) begin
            chk("t5_owner_idle", {30'h0, owner}, 32'h0);
            chk("t5_a_ready", {31'h0, a_ready}, 32'h0);
            chk("t5_b_ready", {31'h0, b_ready}, 32'h0);
            step();
        end
        chk("t5_held_written", sample_count, 37);
        enable = 1'b1;
        drain("t5_drain");
        chk("t5_count", sample_count, 50);

        // 6: async reset while a sample is held
        for (int i = 0; i < 6; i++) begin
            aq.push_back(20'(600 + i));
            exp_q.push_back(20'(600 + i));
        end
        b_gate = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        #1;
        chk("t6_wr_en", {31'h0, fifo_wr_en}, 32'h0);
        chk("t6_din", {12'h0, fifo_din}, 32'h0);
        chk("t6_owner", {30'h0, owner}, 32'h0);
        chk("t6_a_ready", {31'h0, a_ready}, 32'h0);
        chk("t6_count", sample_count, 32'h0);
        exp_q.delete(); aq.delete(); bq.delete();
        a_gate = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        chk("t6_count_after", sample_count, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
